e_mdu: RTL and testbench

- Execute-stage multiply/divide unit. Sits beside the E-stage ALU and takes the same forwarded srcA/srcB operands.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO against architectural HI/LO registers, with a fixed multi-cycle latency.
- Drives busy to the hazard unit, which stalls D while busy or start is high and a new MDU instruction is in D.
- HI/LO feed the E-stage result mux for MFHI/MFLO.

---
 rtl/e_mdu_pkg.sv | 26 ++
 rtl/e_mdu_if.sv | 23 ++
 rtl/e_mdu_calc.sv | 86 ++++++++
 rtl/e_mdu.sv | 97 +++++++++
 tb/tb_e_mdu.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: opcode encodings, widths and default latencies.
// MDU_MADD_EN enables the MADD/MADDU accumulate opcodes.
package e_mdu_pkg;

    localparam int MDU_OP_W       = 4;
    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu_if.sv
// E-stage to MDU bundle: request operands in, busy and HI/LO out.
interface e_mdu_if;
    import e_mdu_pkg::*;

    logic                start;
    logic [MDU_OP_W-1:0] mduOp;
    logic [31:0]         srcA;
    logic [31:0]         srcB;
    logic                busy;
    logic [31:0]         hi;
    logic [31:0]         lo;

    modport master (
        output start, mduOp, srcA, srcB,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mduOp, srcA, srcB,
        output busy, hi, lo
    );

endinterface

// File: rtl/e_mdu_calc.sv
// Combinational MDU arithmetic: 64-bit result, commit-enable and op class.
// MDU_MADD_EN adds the multiply-accumulate path on committed HI/LO.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op_i,
    input  logic [31:0]         a_i,
    input  logic [31:0]         b_i,
    input  logic [31:0]         hi_i,
    input  logic [31:0]         lo_i,
    output logic [63:0]         res_o,
    output logic                we_o,
    output logic                long_o,
    output logic                div_o,
    output logic                mthi_o,
    output logic                mtlo_o
);

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg, sgn;
    logic [31:0] da, db, q, r;
    logic [31:0] q_s, r_s;

    assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // One shared unsigned divider; signed ops divide magnitudes.
    assign sgn   = (op_i == MDU_DIV);
    assign a_neg = sgn & a_i[31];
    assign b_neg = sgn & b_i[31];
    assign da    = a_neg ? -a_i : a_i;
    assign db    = (b_i == 32'd0) ? 32'd1 :
                   (b_neg ? -b_i : b_i);
    assign q     = da / db;
    assign r     = da % db;
    assign q_s   = (a_neg ^ b_neg) ? -q : q;
    assign r_s   = a_neg ? -r : r;

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^{hi_i, lo_i};
`endif

    always_comb begin
        res_o  = 64'd0;
        we_o   = 1'b0;
        long_o = 1'b0;
        div_o  = 1'b0;
        mthi_o = 1'b0;
        mtlo_o = 1'b0;
        unique case (op_i)
            MDU_MULT: begin
                res_o  = prod_s;
                we_o   = 1'b1;
                long_o = 1'b1;
            end
            MDU_MULTU: begin
                res_o  = prod_u;
                we_o   = 1'b1;
                long_o = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                res_o  = {r_s, q_s};
                we_o   = (b_i != 32'd0);
                long_o = 1'b1;
                div_o  = 1'b1;
            end
            MDU_MTHI: mthi_o = 1'b1;
            MDU_MTLO: mtlo_o = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                res_o  = {hi_i, lo_i} + prod_s;
                we_o   = 1'b1;
                long_o = 1'b1;
            end
            MDU_MADDU: begin
                res_o  = {hi_i, lo_i} + prod_u;
                we_o   = 1'b1;
                long_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency FSM over HI/LO.
// MDU_MADD_EN (see e_mdu_calc) enables MADD/MADDU.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic    clk,
    input  logic    reset_n,
    e_mdu_if.slave  bus
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                          MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pwe_q, pwe_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] res;
    logic        we, is_long, is_div, is_mthi, is_mtlo;

    e_mdu_calc u_calc (
        .op_i   (bus.mduOp),
        .a_i    (bus.srcA),
        .b_i    (bus.srcB),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .res_o  (res),
        .we_o   (we),
        .long_o (is_long),
        .div_o  (is_div),
        .mthi_o (is_mthi),
        .mtlo_o (is_mtlo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 64'd0;
            pwe_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pwe_q   <= pwe_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pwe_d   = pwe_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && is_long) begin
                    state_d = ST_RUN;
                    cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                    pend_d  = res;
                    pwe_d   = we;
                end else if (bus.start && is_mthi) begin
                    hi_d = bus.srcA;
                end else if (bus.start && is_mtlo) begin
                    lo_d = bus.srcA;
                end
            end
            ST_RUN: begin
                // start is ignored here; the hazard unit never issues it.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    if (pwe_q) begin
                        {hi_d, lo_d} = pend_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu against a plain-arithmetic HI/LO model.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic [31:0] mhi, mlo;

    e_mdu_if bus ();

    e_mdu #(
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: returns expected busy length and updates mhi/mlo.
    function automatic int model_op(input logic [3:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin
                p = 64'(sa * sb);
                {mhi, mlo} = p;
                return MULC;
            end
            4'd2: begin
                p = {32'd0, a} * {32'd0, b};
                {mhi, mlo} = p;
                return MULC;
            end
            4'd3: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    mlo = q[31:0];
                    mhi = r[31:0];
                end
                return DIVC;
            end
            4'd4: begin
                if (b != 0) begin
                    mlo = a / b;
                    mhi = a % b;
                end
                return DIVC;
            end
            4'd5: begin
                mhi = a;
                return 0;
            end
            4'd6: begin
                mlo = a;
                return 0;
            end
`ifdef MDU_MADD_EN
            4'd7: begin
                p = {mhi, mlo} + 64'(sa * sb);
                {mhi, mlo} = p;
                return MULC;
            end
            4'd8: begin
                p = {mhi, mlo} + {32'd0, a} * {32'd0, b};
                {mhi, mlo} = p;
                return MULC;
            end
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one op at posedge+1 alignment; optionally poke an illegal start mid-run.
    task automatic do_op(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
        int n, exp_n;
        exp_n = model_op(op, a, b);
        bus.start = 1'b1;
        bus.mduOp = op;
        bus.srcA  = a;
        bus.srcB  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 64) begin
            n++;
            if (inject && n == 2) begin
                bus.start = 1'b1;
                bus.mduOp = 4'($urandom_range(1, 8));
                bus.srcA  = $urandom;
                bus.srcB  = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, n, exp_n);
        end
        checks++;
        if (bus.hi !== mhi) begin
            failures++;
            $display("FAIL %s hi got=%h exp=%h", nm, bus.hi, mhi);
        end
        checks++;
        if (bus.lo !== mlo) begin
            failures++;
            $display("FAIL %s lo got=%h exp=%h", nm, bus.lo, mlo);
        end
    endtask

    task automatic chk_hilo(input string nm, input logic [31:0] eh,
                            input logic [31:0] el);
        checks++;
        if (bus.hi !== eh || bus.lo !== el) begin
            failures++;
            $display("FAIL %s hi/lo got=%h/%h exp=%h/%h",
                     nm, bus.hi, bus.lo, eh, el);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.mduOp = 4'd0;
        bus.srcA  = 32'd0;
        bus.srcB  = 32'd0;
        mhi = 32'd0;
        mlo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset busy/hi/lo got=%b/%h/%h exp=0/0/0",
                     bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op("mult_neg3x7", 4'd1, 32'hFFFFFFFD, 32'd7, 1'b0);
        chk_hilo("mult_neg3x7_const", 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("multu_ffx2", 4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk_hilo("multu_ffx2_const", 32'h00000001, 32'hFFFFFFFE);
        do_op("mult_ffx2", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk_hilo("mult_ffx2_const", 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("div_neg7by2", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk_hilo("div_neg7by2_const", 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk_hilo("div_ovf_const", 32'h00000000, 32'h80000000);
        do_op("mthi", 4'd5, 32'h12345678, 32'd0, 1'b0);
        do_op("divu_by0", 4'd4, 32'h00000055, 32'd0, 1'b0);
        chk_hilo("divu_by0_const", 32'h12345678, 32'h80000000);
        do_op("mtlo", 4'd6, 32'hA5A5A5A5, 32'd0, 1'b0);
        chk_hilo("mtlo_const", 32'h12345678, 32'hA5A5A5A5);
        do_op("op_none_12", 4'd12, 32'hDEAD0000, 32'd3, 1'b0);
    endtask

    task automatic test_madd();
        do_op("madd_mthi", 4'd5, 32'd0, 32'd0, 1'b0);
        do_op("madd_mtlo", 4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
        do_op("maddu_1x1", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        chk_hilo("maddu_const", 32'd1, 32'd0);
`else
        chk_hilo("maddu_const", 32'd0, 32'hFFFFFFFF);
`endif
        do_op("madd_neg", 4'd7, 32'hFFFFFFFE, 32'd3, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1;
        bus.mduOp = 4'd1;
        bus.srcA  = 32'h00001234;
        bus.srcB  = 32'h00005678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        mhi = 32'd0;
        mlo = 32'd0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_run busy/hi/lo got=%b/%h/%h exp=0/0/0",
                     bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_op("after_reset_mult", 4'd1, 32'h00001234, 32'h00005678, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op("b2b_div", 4'd3, 32'h7FFFFFFF, 32'hFFFFFFF0, 1'b0);
        do_op("b2b_multu", 4'd2, 32'h89ABCDEF, 32'h13579BDF, 1'b0);
        do_op("b2b_ignored_start", 4'd3, 32'h80000001, 32'd7, 1'b1);
        do_op("b2b_mult_ignored", 4'd1, 32'hC0000000, 32'h40000000, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 5));
            do_op("random", op, a, b, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_madd();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
